// File: rtl/serdesphy_pkg.sv
// Shared types and constants for the SerDes PHY: POR state encoding, PRBS7 helpers, pin map.
// Latency: n/a (declarations only).
// Backpressure: n/a (no datapath here).
package serdesphy_pkg;

  typedef enum logic [2:0] {
    POR_OFF         = 3'd0,
    POR_WAIT_PG     = 3'd1,
    POR_ANALOG_RST  = 3'd2,
    POR_DIGITAL_RST = 3'd3,
    POR_DONE        = 3'd4
  } por_state_e;

  // PRBS7 polynomial x^7 + x^6 + 1 with an all-ones seed
  localparam logic [6:0] PRBS7_SEED = 7'h7F;

  // ui_in bit positions
  localparam int UI_TXD_LSB   = 2;
  localparam int UI_TX_VALID  = 6;
  localparam int UI_TEST_MODE = 7;

  // uio bit positions
  localparam int UIO_TXP  = 2;
  localparam int UIO_TXN  = 3;
  localparam int UIO_RXP  = 4;
  localparam int UIO_RXN  = 5;
  localparam int UIO_LPBK = 6;
  localparam int UIO_DBG  = 7;

  // Next PRBS7 bit from a history register whose bit 0 is the newest bit
  function automatic logic prbs7_fb(input logic [6:0] r);
    return r[6] ^ r[5];
  endfunction

endpackage

// File: rtl/serdesphy_por.sv
// Power-on reset sequencer: OFF -> WAIT_PG -> ANALOG_RST -> DIGITAL_RST -> DONE (terminal).
// Latency: WAIT_PG lasts PG_CYCLES, each reset phase RST_CYCLES; all outputs registered.
// Backpressure: none; free-running once reset is released.
// Ports: clk_i/rst_i (sync, active-high); por_state_o, por_active_o, por_complete_o,
//        power_good_o, analog_iso_n_o, analog_reset_n_o, digital_reset_n_o.
module serdesphy_por #(
  parameter int PG_CYCLES  = 16,
  parameter int RST_CYCLES = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [2:0] por_state_o,
  output logic       por_active_o,
  output logic       por_complete_o,
  output logic       power_good_o,
  output logic       analog_iso_n_o,
  output logic       analog_reset_n_o,
  output logic       digital_reset_n_o
);
  import serdesphy_pkg::*;

  por_state_e por_state;
  logic [7:0] cnt_q;
  logic       por_active_reg;
  logic       por_complete_reg;
  logic       power_good_reg;
  logic       analog_iso_n_reg;
  logic       digital_reset_n_reg;
  logic       analog_reset_n_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      por_state           <= POR_OFF;
      cnt_q               <= '0;
      por_active_reg      <= 1'b0;
      por_complete_reg    <= 1'b0;
      power_good_reg      <= 1'b0;
      analog_iso_n_reg    <= 1'b0;
      digital_reset_n_reg <= 1'b0;
      analog_reset_n_reg  <= 1'b0;
    end else begin
      case (por_state)
        POR_OFF: begin
          por_state      <= POR_WAIT_PG;
          por_active_reg <= 1'b1;
          cnt_q          <= '0;
        end
        POR_WAIT_PG: begin
          if (cnt_q == 8'(PG_CYCLES - 1)) begin
            por_state      <= POR_ANALOG_RST;
            power_good_reg <= 1'b1;
            cnt_q          <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        POR_ANALOG_RST: begin
          if (cnt_q == 8'(RST_CYCLES - 1)) begin
            por_state          <= POR_DIGITAL_RST;
            analog_reset_n_reg <= 1'b1;
            analog_iso_n_reg   <= 1'b1;
            cnt_q              <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        POR_DIGITAL_RST: begin
          if (cnt_q == 8'(RST_CYCLES - 1)) begin
            por_state           <= POR_DONE;
            digital_reset_n_reg <= 1'b1;
            por_complete_reg    <= 1'b1;
            por_active_reg      <= 1'b0;
            cnt_q               <= '0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: por_state <= POR_DONE;
      endcase
    end
  end

  assign por_state_o       = por_state;
  assign por_active_o      = por_active_reg;
  assign por_complete_o    = por_complete_reg;
  assign power_good_o      = power_good_reg;
  assign analog_iso_n_o    = analog_iso_n_reg;
  assign analog_reset_n_o  = analog_reset_n_reg;
  assign digital_reset_n_o = digital_reset_n_reg;

endmodule

// File: rtl/raybello_serdesphy_top.sv
// SerDes PHY top: nibble TX serializer, RX deserializer with CDR lock, PRBS7 gen/check, loopback, POR.
// Latency: loopback nibble loaded at cycle T is presented on rx_data with rx_valid at T+5.
// Backpressure: none; tx_valid is sampled once per 4-cycle frame, rx_valid is a 1-cycle pulse.
// Ports: clk, rst (sync active-high), ena (0 = reset), ui_in (tx_data/tx_valid/test_mode),
//        uo_out (rx_data/pll_lock/cdr_lock/prbs_err/rx_valid), uio_in (rxp/rxn/lpbk_en),
//        uio_out (txp/txn/dbg), uio_oe. Define SERDESPHY_DBG_EN to drive the RX bit on uio[7].
module raybello_serdesphy_top #(
  parameter int POR_PG_CYCLES   = 16,
  parameter int POR_RST_CYCLES  = 8,
  parameter int PLL_LOCK_CYCLES = 32,
  parameter int CDR_LOCK_BITS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import serdesphy_pkg::*;

  logic       srst;
  logic [3:0] tx_data;
  logic       tx_valid, test_mode, rxp, rxn, lpbk_en;

  assign srst      = rst | ~ena;
  assign tx_data   = ui_in[UI_TXD_LSB +: 4];
  assign tx_valid  = ui_in[UI_TX_VALID];
  assign test_mode = ui_in[UI_TEST_MODE];
  assign rxp       = uio_in[UIO_RXP];
  assign rxn       = uio_in[UIO_RXN];
  assign lpbk_en   = uio_in[UIO_LPBK];

  logic [2:0] por_state;
  logic       por_active, por_complete, power_good, analog_iso_n, analog_reset_n, digital_reset_n;

  serdesphy_por #(
    .PG_CYCLES  (POR_PG_CYCLES),
    .RST_CYCLES (POR_RST_CYCLES)
  ) u_por (
    .clk_i             (clk),
    .rst_i             (srst),
    .por_state_o       (por_state),
    .por_active_o      (por_active),
    .por_complete_o    (por_complete),
    .power_good_o      (power_good),
    .analog_iso_n_o    (analog_iso_n),
    .analog_reset_n_o  (analog_reset_n),
    .digital_reset_n_o (digital_reset_n)
  );

  logic [7:0] pll_cnt_q;
  logic       pll_lock_q;
  logic [1:0] phase_q;
  logic [3:0] tx_sh_q;
  logic       tx_bit_q;
  logic [6:0] prbs_gen_q;
  logic       lpbk_q, tm_q;
  logic [3:0] cdr_cnt_q;
  logic       cdr_lock_q;
  logic [1:0] rx_ph_q;
  logic [3:0] rx_sh_q, rx_data_q;
  logic       rx_valid_q;
  logic [6:0] chk_q;
  logic [2:0] chk_fill_q;
  logic       prbs_err_q;

  logic       prbs_bit, rx_bit, rx_bit_ok, rx_cap, chk_exp;
  logic [3:0] rx_word_d;

  assign prbs_bit  = prbs7_fb(prbs_gen_q);
  assign rx_bit    = lpbk_en ? tx_bit_q : rxp;
  assign rx_bit_ok = lpbk_en | (rxp ^ rxn);
  assign rx_word_d = {rx_bit, rx_sh_q[3:1]};
  // Loopback captures one cycle after the TX load phase so the word lines up with the TX frame;
  // external mode frames relative to the cycle cdr_lock rose.
  assign rx_cap    = lpbk_en ? (phase_q == 2'd1) : (rx_ph_q == 2'd3);
  assign chk_exp   = prbs7_fb(chk_q);

  always_ff @(posedge clk) begin
    if (srst) begin
      pll_cnt_q  <= '0;
      pll_lock_q <= 1'b0;
      phase_q    <= '0;
      tx_sh_q    <= '0;
      tx_bit_q   <= 1'b0;
      prbs_gen_q <= PRBS7_SEED;
      lpbk_q     <= 1'b0;
      tm_q       <= 1'b0;
      cdr_cnt_q  <= '0;
      cdr_lock_q <= 1'b0;
      rx_ph_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      chk_q      <= '0;
      chk_fill_q <= '0;
      prbs_err_q <= 1'b0;
    end else begin
      lpbk_q <= lpbk_en;
      tm_q   <= test_mode;
      if (!test_mode) prbs_err_q <= 1'b0;

      if (por_complete && !pll_lock_q) begin
        if (pll_cnt_q == 8'(PLL_LOCK_CYCLES - 1)) pll_lock_q <= 1'b1;
        else                                      pll_cnt_q  <= pll_cnt_q + 8'd1;
      end

      if (pll_lock_q) begin
        phase_q <= phase_q + 2'd1;
        if (test_mode) begin
          tx_bit_q   <= prbs_bit;
          prbs_gen_q <= {prbs_gen_q[5:0], prbs_bit};
        end else begin
          tx_bit_q <= tx_sh_q[0];
        end
        if (phase_q == 2'd0) tx_sh_q <= (tx_valid && !test_mode) ? tx_data : 4'd0;
        else                 tx_sh_q <= {1'b0, tx_sh_q[3:1]};

        if (!rx_bit_ok || (lpbk_en != lpbk_q)) begin
          cdr_cnt_q  <= '0;
          cdr_lock_q <= 1'b0;
        end else if (cdr_cnt_q == 4'(CDR_LOCK_BITS - 1)) begin
          cdr_lock_q <= 1'b1;
        end else begin
          cdr_cnt_q <= cdr_cnt_q + 4'd1;
        end

        rx_sh_q    <= rx_word_d;
        rx_ph_q    <= cdr_lock_q ? rx_ph_q + 2'd1 : 2'd0;
        rx_valid_q <= rx_cap && cdr_lock_q;
        if (rx_cap && cdr_lock_q) rx_data_q <= rx_word_d;

        // Checker uses the registered test_mode so the last data bit still in flight on the
        // loopback path when PRBS starts never enters the comparison window.
        if (rx_bit_ok) chk_q <= {chk_q[5:0], rx_bit};
        if (!tm_q || !cdr_lock_q)                  chk_fill_q <= '0;
        else if (rx_bit_ok && chk_fill_q != 3'd7)  chk_fill_q <= chk_fill_q + 3'd1;
        if (test_mode && tm_q && cdr_lock_q && rx_bit_ok && chk_fill_q == 3'd7 && rx_bit != chk_exp)
          prbs_err_q <= 1'b1;
      end
    end
  end

  assign uo_out = {rx_valid_q, prbs_err_q, cdr_lock_q, pll_lock_q, rx_data_q};

  always_comb begin
    uio_out          = '0;
    uio_out[UIO_TXP] = tx_bit_q;
    uio_out[UIO_TXN] = ~tx_bit_q;
`ifdef SERDESPHY_DBG_EN
    uio_out[UIO_DBG] = rx_bit & pll_lock_q;
`endif
  end

`ifdef SERDESPHY_DBG_EN
  assign uio_oe = 8'b1000_1100;
`else
  assign uio_oe = 8'b0000_1100;
`endif

  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in[1:0], uio_in[3:0], uio_in[7], por_state, por_active,
                       power_good, analog_iso_n, analog_reset_n, digital_reset_n};

endmodule

// File: tb/tb_raybello_serdesphy_top.sv
module tb_raybello_serdesphy_top;

  logic       clk, rst, ena;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
  logic [3:0] tx_data;
  logic       tx_valid, test_mode, rxp, rxn, lpbk_en;

  int checks = 0;
  int errors = 0;

`ifdef SERDESPHY_DBG_EN
  localparam logic DBG = 1'b1;
`else
  localparam logic DBG = 1'b0;
`endif

  assign ui_in  = {test_mode, tx_valid, tx_data, 2'b00};
  assign uio_in = {1'b0, lpbk_en, rxn, rxp, 4'b0000};

  raybello_serdesphy_top dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] st();
    return 8'(dut.u_por.por_state);
  endfunction

  logic [6:0] lfsr;
  logic       b;

  initial begin
    rst = 1'b1; ena = 1'b1;
    tx_data = 4'hA; tx_valid = 1'b1; test_mode = 1'b0;
    rxp = 1'b0; rxn = 1'b0; lpbk_en = 1'b1;
    tick(3);
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h08);
    check("rst_uio_oe", uio_oe, {DBG, 7'b000_1100});
    check("rst_state", st(), 8'd0);

    // POR sequence; E0 is the first edge with rst low
    rst = 1'b0;
    tick(1);  check("por_wait_pg", st(), 8'd1);
    tick(15); check("por_wait_pg_end", st(), 8'd1);
    check("pg_low", 8'(dut.u_por.power_good_reg), 8'd0);
    tick(1);  check("por_analog", st(), 8'd2);
    check("pg_high", 8'(dut.u_por.power_good_reg), 8'd1);
    tick(7);  check("por_analog_end", st(), 8'd2);
    tick(1);  check("por_digital", st(), 8'd3);
    check("arst_n", 8'(dut.u_por.analog_reset_n_reg), 8'd1);
    tick(8);  check("por_done", st(), 8'd4);
    check("por_complete", 8'(dut.u_por.por_complete_reg), 8'd1);
    check("por_active", 8'(dut.u_por.por_active_reg), 8'd0);
    tick(31); check("pll_not_yet", uo_out, 8'h00);
    tick(1);  check("pll_lock", uo_out, 8'h10);
    check("tx_idle", uio_out, 8'h08);

    // Loopback: nibble A loaded at E65, E69, ...; cdr_lock after E72
    tick(7);  check("cdr_lb_7", uo_out[5:4], 2'b01);
    tick(1);  check("cdr_lb_8", uo_out[5:4], 2'b11);
    tick(1);  check("lb_no_valid", uo_out, 8'h30);
    tick(1);  check("lb_rx_A", uo_out, 8'hBA);
    tick(1);  check("lb_hold_A", uo_out, 8'h3A);
    tx_data = 4'h5;                 // loaded at E77
    tick(3);  check("txp_bit0", uio_out, {DBG, 7'b000_0100});
    tick(1);  check("txp_bit1", uio_out, 8'h08);
    tick(3);  check("lb_rx_5", uo_out, 8'hB5);
    tx_valid = 1'b0; tx_data = 4'hF; // E85 loads zero
    tick(4);  check("lb_rx_5b", uo_out, 8'hB5);
    tick(3);
    tx_valid = 1'b1; tx_data = 4'hC; // high only off the load phase
    tick(1);  check("lb_rx_0", uo_out, 8'hB0);
    tick(2);
    tx_valid = 1'b0;
    tick(6);  check("lb_valid_phase0", uo_out, 8'hB0);

    // External differential RX
    lpbk_en = 1'b0; rxp = 1'b1; rxn = 1'b0;
    tick(1);  check("ext_lpbk_clr", uo_out[5], 1'b0);
    tick(7);  check("ext_cdr_7", uo_out[5], 1'b0);
    tick(1);  check("ext_cdr_8", uo_out[5], 1'b1);
    rxp = 1'b1; rxn = 1'b1;
    tick(1);  check("ext_cdr_drop", uo_out[5], 1'b0);
    check("ext_no_valid", uo_out[7], 1'b0);

    // PRBS7 in loopback: TX sequence compared against an independent LFSR model
    test_mode = 1'b1; lpbk_en = 1'b1;
    lfsr = 7'h7F;
    for (int i = 0; i < 200; i++) begin
      b = lfsr[6] ^ lfsr[5];
      lfsr = {lfsr[5:0], b};
      tick(1);
      if (i < 24) check("prbs_txp", uio_out[2], b);
    end
    check("prbs_lb_err", uo_out[6], 1'b0);
    check("prbs_lb_cdr", uo_out[5], 1'b1);

    // PRBS7 fed externally, with an invalid bit and then a flipped bit
    lpbk_en = 1'b0;
    for (int i = 0; i < 30; i++) begin
      b = lfsr[6] ^ lfsr[5]; lfsr = {lfsr[5:0], b};
      rxp = b; rxn = ~b;
      tick(1);
    end
    check("prbs_ext_err0", uo_out[6], 1'b0);
    check("prbs_ext_cdr", uo_out[5], 1'b1);
    rxp = 1'b0; rxn = 1'b0;
    tick(1);  check("prbs_ext_drop", uo_out[5], 1'b0);
    for (int i = 0; i < 20; i++) begin
      b = lfsr[6] ^ lfsr[5]; lfsr = {lfsr[5:0], b};
      rxp = b; rxn = ~b;
      tick(1);
    end
    check("prbs_no_false_err", uo_out[6:5], 2'b01);
    b = lfsr[6] ^ lfsr[5]; lfsr = {lfsr[5:0], b};
    rxp = ~b; rxn = b;
    tick(1);  check("prbs_err_set", uo_out[6], 1'b1);
    for (int i = 0; i < 5; i++) begin
      b = lfsr[6] ^ lfsr[5]; lfsr = {lfsr[5:0], b};
      rxp = b; rxn = ~b;
      tick(1);
    end
    check("prbs_err_sticky", uo_out[6], 1'b1);
    test_mode = 1'b0;
    tick(1);  check("prbs_err_clr", uo_out[6], 1'b0);

    // ena low mid-traffic behaves as reset, then the POR restarts
    lpbk_en = 1'b1; tx_valid = 1'b1; tx_data = 4'hA;
    tick(6);
    ena = 1'b0;
    tick(1);  check("ena_uo", uo_out, 8'h00);
    check("ena_state", st(), 8'd0);
    check("ena_uio_out", uio_out, 8'h08);
    check("ena_uio_oe", uio_oe, {DBG, 7'b000_1100});
    ena = 1'b1;
    tick(1);  check("re_wait_pg", st(), 8'd1);
    tick(16); check("re_analog", st(), 8'd2);
    check("re_pll_off", uo_out[4], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
